mips_data_mem: RTL

- Data memory stage directly downstream of the single-cycle ALU.
- ALUResult is the byte address; the register-file second read operand is the store data.
- Supports byte/half/word loads and stores, little-endian lane selection, and sign/zero extension.
- Flags misaligned and out-of-range accesses and keeps a sticky first-error record for debug.

---
 rtl/mips_data_mem_if.sv | 41 ++++
 rtl/mips_data_mem.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mips_data_mem_if.sv
// Load/store bus between the ALU stage and the data memory.
// Ports: address, store data, controls in; load data, error flags out.
interface mips_data_mem_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0] ALUResult;
  logic [DATA_SIZE-1:0] WriteData;
  logic                 MemWrite;
  logic                 MemRead;
  logic [1:0]           MemSize;
  logic                 MemUnsigned;
  logic [DATA_SIZE-1:0] ReadData;
  logic                 MisalignErr;
  logic                 RangeErr;
  logic                 ErrFlag;
  logic [DATA_SIZE-1:0] ErrAddr;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0]          LoadCount;
  logic [31:0]          StoreCount;
`endif

  modport master (
    output ALUResult, WriteData, MemWrite,
    output MemRead, MemSize, MemUnsigned,
    input  ReadData, MisalignErr, RangeErr,
    input  ErrFlag, ErrAddr
`ifdef DMEM_ACCESS_CNT_EN
    , input LoadCount, StoreCount
`endif
  );

  modport slave (
    input  ALUResult, WriteData, MemWrite,
    input  MemRead, MemSize, MemUnsigned,
    output ReadData, MisalignErr, RangeErr,
    output ErrFlag, ErrAddr
`ifdef DMEM_ACCESS_CNT_EN
    , output LoadCount, StoreCount
`endif
  );
endinterface

// File: rtl/mips_data_mem.sv
// Byte-addressed little-endian data memory with sticky error record.
// Ports: clk, rst (sync, active-high), bus (slave side of
// mips_data_mem_if). Define DMEM_ACCESS_CNT_EN for load/store counters.
module mips_data_mem #(
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  mips_data_mem_if.slave     bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          err_flag_q;
  logic [31:0]   err_addr_q;

  logic          access;
  logic          is_half;
  logic          is_word;
  logic          mis;
  logic          rng;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [4:0]    bsh;
  logic [4:0]    hsh;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rdata;
  logic [31:0]   wmask;
  logic [31:0]   wval;
  logic [31:0]   word_d;

  assign access  = bus.MemRead | bus.MemWrite;
  assign is_half = (bus.MemSize == 2'b01);
  // Reserved size 11 behaves as a word.
  assign is_word = bus.MemSize[1];
  assign mis     = access &
                   ((is_half & bus.ALUResult[0]) |
                    (is_word & (bus.ALUResult[1:0] != 2'b00)));
  assign rng     = access &
                   (bus.ALUResult[DATA_SIZE-1:AW+2] != '0);
  assign err     = mis | rng;

  assign idx   = bus.ALUResult[AW+1:2];
  assign rword = mem_q[idx];
  assign bsh   = {bus.ALUResult[1:0], 3'b000};
  assign hsh   = {bus.ALUResult[1], 4'b0000};
  assign rbyte = 8'(rword >> bsh);
  assign rhalf = 16'(rword >> hsh);

  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      is_word: rdata = rword;
      is_half: rdata = bus.MemUnsigned ?
                       {16'h0, rhalf} :
                       {{16{rhalf[15]}}, rhalf};
      default: rdata = bus.MemUnsigned ?
                       {24'h0, rbyte} :
                       {{24{rbyte[7]}}, rbyte};
    endcase
  end

  assign bus.ReadData    = (bus.MemRead & ~err) ? rdata : 32'h0;
  assign bus.MisalignErr = mis;
  assign bus.RangeErr    = rng;
  assign bus.ErrFlag     = err_flag_q;
  assign bus.ErrAddr     = err_addr_q;

  // Lane merge: untouched lanes keep the current word.
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    wval  = bus.WriteData;
    unique case (1'b1)
      is_word: begin
        wmask = 32'hFFFF_FFFF;
        wval  = bus.WriteData;
      end
      is_half: begin
        wmask = 32'h0000_FFFF << hsh;
        wval  = {16'h0, bus.WriteData[15:0]} << hsh;
      end
      default: begin
        wmask = 32'h0000_00FF << bsh;
        wval  = {24'h0, bus.WriteData[7:0]} << bsh;
      end
    endcase
    word_d = (rword & ~wmask) | (wval & wmask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem_q[i] <= 32'h0;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      if (bus.MemWrite && !err)
        mem_q[idx] <= word_d;
      if (err && !err_flag_q) begin
        err_flag_q <= 1'b1;
        err_addr_q <= bus.ALUResult;
      end
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= 32'h0;
      store_cnt_q <= 32'h0;
    end else begin
      if (bus.MemRead && !err)
        load_cnt_q <= load_cnt_q + 32'h1;
      if (bus.MemWrite && !err)
        store_cnt_q <= store_cnt_q + 32'h1;
    end
  end

  assign bus.LoadCount  = load_cnt_q;
  assign bus.StoreCount = store_cnt_q;
`endif
endmodule
